// File: rtl/q_seq_pkg.sv
// q_seq_pkg: shared types and constants for the two-qubit gate sequencer.
//   q_op_e        : 3-bit gate opcode (6/7 are illegal, executed as NOP)
//   q_seq_state_e : sequencer FSM state
//   q_amp_t       : one complex amplitude {re, im}, signed fixed point
//   AMP_ONE       : amplitude 1.0 + 0i, the |00> reset value
// The fixed-point macros get local fallbacks so the slice builds on its own.
// When the surrounding datapath defines them, those definitions take over.
`ifndef FIXED_WIDTH
`define FIXED_WIDTH 16
`endif
`ifndef SCALE_FACTOR
`define SCALE_FACTOR 256
`endif
`ifndef FIXED_POINT_CONST_1
`define FIXED_POINT_CONST_1 (`SCALE_FACTOR)
`endif

package q_seq_pkg;

    // Amplitude component width used by q_amp_t.
    localparam int FW = `FIXED_WIDTH;

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_CNOT_C1T0 = 3'd1,
        OP_CNOT_C0T1 = 3'd2,
        OP_X_T       = 3'd3,
        OP_X_C       = 3'd4,
        OP_SWAP      = 3'd5,
        OP_ILL6      = 3'd6,
        OP_ILL7      = 3'd7
    } q_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } q_seq_state_e;

    typedef struct packed {
        logic signed [FW-1:0] re;
        logic signed [FW-1:0] im;
    } q_amp_t;

    localparam q_amp_t AMP_ONE  = '{re: FW'(`FIXED_POINT_CONST_1), im: '0};
    localparam q_amp_t AMP_ZERO = '{re: '0, im: '0};

    function automatic logic op_illegal(input logic [2:0] op);
        return op > 3'd5;
    endfunction

endpackage

// File: rtl/q_perm4.sv
// q_perm4: combinational permutation of the four amplitudes of a 2-qubit
// state vector. No arithmetic is done, so the result is bit-exact.
//   amp_i : four input amplitudes, index {control,target}
//   op_i  : gate opcode; illegal codes pass the vector through unchanged
//   amp_o : permuted amplitudes
module q_perm4
    import q_seq_pkg::*;
(
    input  q_amp_t [3:0] amp_i,
    input  logic   [2:0] op_i,
    output q_amp_t [3:0] amp_o
);

    always_comb begin
        amp_o = amp_i;
        case (op_i)
            OP_CNOT_C1T0: begin
                amp_o[2] = amp_i[3];
                amp_o[3] = amp_i[2];
            end
            OP_CNOT_C0T1: begin
                amp_o[1] = amp_i[3];
                amp_o[3] = amp_i[1];
            end
            OP_X_T: begin
                amp_o[0] = amp_i[1];
                amp_o[1] = amp_i[0];
                amp_o[2] = amp_i[3];
                amp_o[3] = amp_i[2];
            end
            OP_X_C: begin
                amp_o[0] = amp_i[2];
                amp_o[2] = amp_i[0];
                amp_o[1] = amp_i[3];
                amp_o[3] = amp_i[1];
            end
            OP_SWAP: begin
                amp_o[1] = amp_i[2];
                amp_o[2] = amp_i[1];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/q_gate_seq.sv
// q_gate_seq: two-qubit gate program sequencer.
// Holds a 4-amplitude state vector and a command FIFO. In IDLE the host
// loads amplitudes. On start the FIFO is drained one command per cycle
// through q_perm4 until the command marked last. The four amplitudes are
// then streamed out with a valid/ready handshake.
//   clk, rst_n             : clock, synchronous active-low reset
//   load_*                 : amplitude write port (IDLE only)
//   cmd_*                  : command push port (any state)
//   start                  : begin execution (IDLE only)
//   busy, done, err        : status; err is sticky until the next start
//   out_*                  : readout stream, idx 0..3
module q_gate_seq
    import q_seq_pkg::*;
#(
    parameter int FIXED_WIDTH = `FIXED_WIDTH,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [1:0]                    load_idx,
    input  logic signed [FIXED_WIDTH-1:0] load_real,
    input  logic signed [FIXED_WIDTH-1:0] load_imag,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_op,
    input  logic                          cmd_last,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [1:0]                    out_idx,
    output logic signed [FIXED_WIDTH-1:0] out_real,
    output logic signed [FIXED_WIDTH-1:0] out_imag
);

    localparam int AW = $clog2(FIFO_DEPTH);

    q_seq_state_e state_q, state_d;

    // Command FIFO: each entry is {op, last}.
    logic [FIFO_DEPTH-1:0][3:0] mem_q;
    logic [AW-1:0]              wr_ptr_q, rd_ptr_q;
    logic [AW:0]                cnt_q, cnt_d;
    logic                       push, pop;
    logic [2:0]                 head_op;
    logic                       head_last;

    q_amp_t [3:0] amp_q, amp_d, perm_amp;
    q_amp_t       out_amp_q, out_amp_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic         out_valid_q, out_valid_d;
    logic [1:0]   out_idx_q, out_idx_d, nxt_idx;
    logic         drain_hs;

    // A full FIFO refuses pushes even when a pop happens in the same cycle.
    assign cmd_ready  = (cnt_q != (AW+1)'(FIFO_DEPTH));
    assign load_ready = (state_q == ST_IDLE);
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state_q == ST_RUN) && (cnt_q != '0);
    assign {head_op, head_last} = mem_q[rd_ptr_q];
    assign drain_hs   = (state_q == ST_DRAIN) && out_valid_q && out_ready;
    assign nxt_idx    = out_idx_q + 2'd1;

    q_perm4 u_perm (
        .amp_i (amp_q),
        .op_i  (head_op),
        .amp_o (perm_amp)
    );

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: ;
        endcase
    end

    // FIFO storage needs no reset; occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_last};
    end

    // State register (plus FIFO pointers and all registered outputs).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            amp_q       <= {AMP_ZERO, AMP_ZERO, AMP_ZERO, AMP_ONE};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_amp_q   <= AMP_ZERO;
        end else begin
            state_q     <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q       <= cnt_d;
            amp_q       <= amp_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_amp_q   <= out_amp_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (pop && head_last) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_hs && out_idx_q == 2'd3) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output and datapath logic, computed one cycle ahead so every output
    // leaves a register.
    always_comb begin
        amp_d       = amp_q;
        err_d       = err_q;
        done_d      = 1'b0;
        busy_d      = (state_d != ST_IDLE);
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_amp_d   = out_amp_q;
        case (state_q)
            ST_IDLE: begin
                // The load lands at the same edge as start, so it is seen by the program.
                if (load_valid)
                    amp_d[load_idx] = '{re: FW'(load_real), im: FW'(load_imag)};
                if (start) err_d = 1'b0;
            end
            ST_RUN: begin
                if (pop) begin
                    amp_d = perm_amp;
                    if (op_illegal(head_op)) err_d = 1'b1;
                    if (head_last) begin
                        out_valid_d = 1'b1;
                        out_idx_d   = 2'd0;
                        out_amp_d   = perm_amp[0];
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_hs) begin
                    if (out_idx_q == 2'd3) begin
                        out_valid_d = 1'b0;
                        out_idx_d   = 2'd0;
                        out_amp_d   = AMP_ZERO;
                        done_d      = 1'b1;
                    end else begin
                        out_idx_d = nxt_idx;
                        out_amp_d = amp_q[nxt_idx];
                    end
                end
            end
            default: ;
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_real  = FIXED_WIDTH'(out_amp_q.re);
    assign out_imag  = FIXED_WIDTH'(out_amp_q.im);

endmodule

// File: tb/tb_q_gate_seq.sv
// tb_q_gate_seq: scoreboard bench for q_gate_seq. The reference model
// applies the gate swaps to a plain array and then queues the expected readout.
// An independent monitor pops the queue on every output handshake.
module tb_q_gate_seq;
    import q_seq_pkg::*;

    localparam int W = `FIXED_WIDTH;
    localparam int D = 4;
    localparam logic signed [W-1:0] ONE  = `FIXED_POINT_CONST_1;
    localparam logic signed [W-1:0] HALF = ONE / 2;
    localparam logic signed [W-1:0] QRT  = ONE / 4;

    logic clk = 1'b0, rst_n = 1'b0;
    logic load_valid = 1'b0, load_ready;
    logic [1:0] load_idx = '0;
    logic signed [W-1:0] load_real = '0, load_imag = '0;
    logic cmd_valid = 1'b0, cmd_ready, cmd_last = 1'b0;
    logic [2:0] cmd_op = '0;
    logic start = 1'b0, busy, done, err;
    logic out_valid, out_ready = 1'b1;
    logic [1:0] out_idx;
    logic signed [W-1:0] out_real, out_imag;

    always #5 clk = ~clk;

    q_gate_seq #(.FIXED_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_valid(load_valid), .load_ready(load_ready), .load_idx(load_idx),
        .load_real(load_real), .load_imag(load_imag),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_last(cmd_last),
        .start(start), .busy(busy), .done(done), .err(err),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_real(out_real), .out_imag(out_imag)
    );

    int tests = 0, fails = 0, done_cnt = 0, rdy_mode = 0;

    typedef struct { logic [1:0] idx; logic signed [W-1:0] re; logic signed [W-1:0] im; } exp_t;
    typedef struct { int op; bit last; } cmd_t;
    exp_t sb[$];
    cmd_t mq[$];
    logic signed [W-1:0] m_re[4], m_im[4];
    bit m_err;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void m_swap(input int a, input int b);
        logic signed [W-1:0] tr, ti;
        tr = m_re[a]; ti = m_im[a];
        m_re[a] = m_re[b]; m_im[a] = m_im[b];
        m_re[b] = tr; m_im[b] = ti;
    endfunction

    function automatic void m_apply(input int op);
        case (op)
            1: m_swap(2, 3);
            2: m_swap(1, 3);
            3: begin m_swap(0, 1); m_swap(2, 3); end
            4: begin m_swap(0, 2); m_swap(1, 3); end
            5: m_swap(1, 2);
            6, 7: m_err = 1'b1;
            default: ;
        endcase
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 4; i++) begin m_re[i] = '0; m_im[i] = '0; end
        m_re[0] = ONE;
        m_err = 1'b0;
        mq.delete();
        sb.delete();
    endfunction

    // Run the queued program up to its last command and queue the readout.
    function automatic void expect_program();
        cmd_t c;
        exp_t e;
        m_err = 1'b0;
        while (mq.size() > 0) begin
            c = mq.pop_front();
            m_apply(c.op);
            if (c.last) break;
        end
        for (int i = 0; i < 4; i++) begin
            e.idx = 2'(i); e.re = m_re[i]; e.im = m_im[i];
            sb.push_back(e);
        end
    endfunction

    // ---------------- readout driver / monitor ----------------
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    logic pv = 1'b0, pr = 1'b0;
    logic [1:0] pidx;
    logic signed [W-1:0] pre, pim;
    exp_t me;

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (pv && !pr) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_idx", out_idx, pidx);
                chk("hold_real", out_real, pre);
                chk("hold_imag", out_imag, pim);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_out: got idx %0d with no expected entry", out_idx);
                end else begin
                    me = sb.pop_front();
                    chk("out_idx", out_idx, me.idx);
                    chk("out_real", out_real, me.re);
                    chk("out_imag", out_imag, me.im);
                end
            end
        end
        pv = out_valid && rst_n; pr = out_ready;
        pidx = out_idx; pre = out_real; pim = out_imag;
    end

    // ---------------- stimulus tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        m_reset();
    endtask

    task automatic load(input int idx, input logic signed [W-1:0] re, input logic signed [W-1:0] im);
        load_valid = 1'b1; load_idx = 2'(idx); load_real = re; load_imag = im;
        cyc(1);
        load_valid = 1'b0;
        m_re[idx] = re; m_im[idx] = im;
    endtask

    task automatic push(input int op, input bit last, input bit with_start);
        cmd_t c;
        bit ok = 1'b0;
        cmd_valid = 1'b1; cmd_op = 3'(op); cmd_last = last;
        if (with_start) start = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        cmd_valid = 1'b0;
        if (!ok) begin
            tests++; fails++;
            $display("FAIL push_timeout: got cmd_ready 0 for 200 cycles expected 1");
        end
        c.op = op; c.last = last;
        mq.push_back(c);
    endtask

    task automatic wait_done();
        int c0 = done_cnt;
        bit seen = 1'b0;
        for (int k = 0; k < 1000 && !seen; k++) begin
            @(negedge clk);
            seen = (done_cnt > c0);
        end
        if (!seen) begin
            tests++; fails++;
            $display("FAIL done_timeout: got no done expected one within 1000 cycles");
        end
        cyc(2);
        chk("done_once", done_cnt - c0, 1);
        chk("sb_drained", sb.size(), 0);
        chk("err_flag", err, m_err);
        chk("busy_after", busy, 0);
    endtask

    task automatic run_prog(input int ops[8], input int n);
        int npre;
        npre = (n > D) ? D : n;
        for (int i = 0; i < npre; i++) push(ops[i], (i == n - 1), 1'b0);
        if (n > D) begin
            @(negedge clk);
            chk("fifo_full_ready", cmd_ready, 0);
            for (int i = D; i < n; i++) push(ops[i], (i == n - 1), (i == D));
        end else begin
            start = 1'b1;
            cyc(1);
            start = 1'b0;
            @(negedge clk);
            chk("err_cleared", err, 0);
            chk("busy_run", busy, 1);
            chk("load_ready_run", load_ready, 0);
            // A load outside IDLE must be ignored.
            load_valid = 1'b1; load_idx = 2'($urandom_range(0, 3));
            load_real = W'($urandom); load_imag = W'($urandom);
            cyc(1);
            load_valid = 1'b0;
        end
        expect_program();
        wait_done();
    endtask

    // ---------------- test sequence ----------------
    int ops[8];
    int n;
    bit seen;

    initial begin
        do_reset();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_real", out_real, 0);
        chk("rst_out_imag", out_imag, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_load_ready", load_ready, 1);
        cyc(1);

        // |00> readout through a single NOP.
        ops[0] = 0;
        run_prog(ops, 1);

        // |10> through CNOT_C1T0 -> |11>.
        load(0, '0, '0);
        load(2, ONE, '0);
        ops[0] = 1;
        run_prog(ops, 1);

        // Three-gate program with mixed amplitudes.
        load(0, HALF, '0);
        load(1, '0, QRT);
        load(2, -HALF, '0);
        load(3, '0, -QRT);
        ops[0] = 4; ops[1] = 5; ops[2] = 2;
        run_prog(ops, 3);

        // Five commands through a depth-4 FIFO.
        load(0, 11, -3); load(1, 22, 5); load(2, -33, 7); load(3, 44, -9);
        ops[0] = 3; ops[1] = 4; ops[2] = 5; ops[3] = 1; ops[4] = 2;
        run_prog(ops, 5);

        // Backpressure on readout plus an illegal opcode mid-program.
        rdy_mode = 2;
        ops[0] = 3; ops[1] = 7; ops[2] = 5;
        for (int i = 0; i < 3; i++) push(ops[i], (i == 2), 1'b0);
        start = 1'b1; cyc(1); start = 1'b0;
        expect_program();
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin @(negedge clk); seen = out_valid; end
        chk("bp_out_valid", out_valid, 1);
        cyc(4);
        rdy_mode = 0;
        wait_done();
        // err is cleared by the next start.
        ops[0] = 0;
        run_prog(ops, 1);

        // Reset in RUN with two entries still queued.
        for (int i = 0; i < 4; i++) push(3, (i == 3), 1'b0);
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(2);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        m_reset();
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        chk("mid_rst_load_ready", load_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        cyc(1);
        ops[0] = 0;
        run_prog(ops, 1);

        // Randomized programs with random readout backpressure.
        rdy_mode = 1;
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 1) == 1) load(i, W'($urandom), W'($urandom));
            n = $urandom_range(1, 7);
            for (int i = 0; i < n; i++)
                ops[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
            run_prog(ops, n);
        end
        rdy_mode = 0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
